// File: rtl/player_select_input.sv
// player_select_input: debounced two-player door selector driving posJ1/posJ2
// Ports: clk; reset (async, active-low); btn_{prev,next}_j{1,2} raw active-high buttons;
//   freeze holds both selections; clear zeroes both selections;
//   posJ1/posJ2 current door (0 = none, 1..NUM_POS); move_j1/move_j2 one-cycle step pulses.
module player_select_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_POS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_prev_j1,
  input  logic       btn_next_j1,
  input  logic       btn_prev_j2,
  input  logic       btn_next_j2,
  input  logic       freeze,
  input  logic       clear,
  output logic [3:0] posJ1,
  output logic [3:0] posJ2,
  output logic       move_j1,
  output logic       move_j2
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The flip happens on the DEBOUNCE_CYCLES-th mismatching sample, i.e. when the count already holds one less.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] TOP = 4'(NUM_POS);
  logic [3:0] raw, s1, s2, stab, stab_d, press;
  logic [1:0][3:0] pos;
  logic [1:0] move;
  assign raw = {btn_next_j2, btn_prev_j2, btn_next_j1, btn_prev_j1};
  assign press = stab & ~stab_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      stab_d <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      stab_d <= stab;
    end
  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic st;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        cnt <= '0;
        st <= 1'b0;
      end else if (s2[i] == st) cnt <= '0;
      else if (cnt == LAST) begin
        cnt <= '0;
        st <= s2[i];
      end else cnt <= cnt + 1'b1;
    assign stab[i] = st;
  end
  for (genvar p = 0; p < 2; p++) begin : g_pl
    logic prv, nxt, step, mv;
    logic [3:0] r, nv;
    assign prv = press[2*p];
    assign nxt = press[2*p+1];
    // Strobes arriving under clear/freeze or together are dropped, not queued.
    assign step = ~clear & ~freeze & (prv ^ nxt);
    assign nv = nxt ? ((r == 4'd0 || r == TOP) ? 4'd1 : r + 4'd1)
                    : ((r <= 4'd1) ? TOP : r - 4'd1);
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        r <= '0;
        mv <= 1'b0;
      end else begin
        r <= clear ? 4'd0 : step ? nv : r;
        mv <= step;
      end
    assign pos[p] = r;
    assign move[p] = mv;
  end
  assign posJ1 = pos[0];
  assign posJ2 = pos[1];
  assign move_j1 = move[0];
  assign move_j2 = move[1];
endmodule

// File: tb/tb_player_select_input.sv
// tb_player_select_input: vector table plus corner sequences for player_select_input
module tb_player_select_input;
  logic clk = 0, reset = 0;
  logic btn_prev_j1 = 0, btn_next_j1 = 0, btn_prev_j2 = 0, btn_next_j2 = 0;
  logic freeze = 0, clear = 0;
  logic [3:0] posJ1, posJ2;
  logic move_j1, move_j2;
  int checks = 0, errors = 0, n1 = 0, n2 = 0;
  typedef struct {
    logic [3:0] btn;
    logic frz, clr;
    int hi, p1, p2, m1, m2;
  } vec_t;
  typedef struct {
    int p1, p2, m1, m2;
  } exp_t;
  vec_t v[19];
  exp_t sb[$];
  always #5 clk = ~clk;
  player_select_input #(.DEBOUNCE_CYCLES(4), .NUM_POS(6)) dut (
    .clk(clk), .reset(reset),
    .btn_prev_j1(btn_prev_j1), .btn_next_j1(btn_next_j1),
    .btn_prev_j2(btn_prev_j2), .btn_next_j2(btn_next_j2),
    .freeze(freeze), .clear(clear),
    .posJ1(posJ1), .posJ2(posJ2), .move_j1(move_j1), .move_j2(move_j2)
  );
  always @(negedge clk) begin
    if (move_j1) n1++;
    if (move_j2) n2++;
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set(input logic [3:0] b);
    {btn_next_j2, btn_prev_j2, btn_next_j1, btn_prev_j1} = b;
  endtask
  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  initial begin
    int first, cnt, b1, b2;
    exp_t e;
    // btn bits: [0]=prev_j1 [1]=next_j1 [2]=prev_j2 [3]=next_j2
    v[0]  = '{4'b0010, 0, 0, 8, 1, 0, 1, 0};
    v[1]  = '{4'b0010, 0, 0, 8, 2, 0, 1, 0};
    v[2]  = '{4'b0010, 0, 0, 8, 3, 0, 1, 0};
    v[3]  = '{4'b0010, 0, 0, 8, 4, 0, 1, 0};
    v[4]  = '{4'b0010, 0, 0, 8, 5, 0, 1, 0};
    v[5]  = '{4'b0010, 0, 0, 8, 6, 0, 1, 0};
    v[6]  = '{4'b0010, 0, 0, 8, 1, 0, 1, 0};
    v[7]  = '{4'b0001, 0, 0, 8, 6, 0, 1, 0};
    v[8]  = '{4'b0000, 0, 1, 2, 0, 0, 0, 0};
    v[9]  = '{4'b0001, 0, 0, 8, 6, 0, 1, 0};
    v[10] = '{4'b0010, 0, 0, 3, 6, 0, 0, 0};
    v[11] = '{4'b0010, 0, 0, 3, 6, 0, 0, 0};
    v[12] = '{4'b0010, 0, 0, 6, 1, 0, 1, 0};
    v[13] = '{4'b1011, 0, 0, 8, 1, 1, 0, 1};
    v[14] = '{4'b0100, 0, 0, 8, 1, 6, 0, 1};
    v[15] = '{4'b0110, 0, 0, 8, 2, 5, 1, 1};
    v[16] = '{4'b0010, 1, 0, 8, 2, 5, 0, 0};
    v[17] = '{4'b1010, 1, 1, 8, 0, 0, 0, 0};
    v[18] = '{4'b1000, 0, 0, 8, 0, 1, 0, 1};
    cyc(3);
    chk("reset posJ1", posJ1, 0);
    chk("reset posJ2", posJ2, 0);
    chk("reset move_j1", move_j1, 0);
    chk("reset move_j2", move_j2, 0);
    reset = 1;
    cyc(2);
    set(4'b0010);
    first = 0;
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc(1);
      if (move_j1) begin
        cnt++;
        if (first == 0) first = c;
      end
    end
    chk("latency cycle", first, 7);
    chk("latency pulses", cnt, 1);
    chk("latency posJ1", posJ1, 1);
    set(4'b0000);
    cyc(10);
    clear = 1;
    cyc(1);
    clear = 0;
    chk("clear posJ1", posJ1, 0);
    for (int i = 0; i < 19; i++) begin
      sb.push_back('{v[i].p1, v[i].p2, v[i].m1, v[i].m2});
      b1 = n1;
      b2 = n2;
      freeze = v[i].frz;
      clear = v[i].clr;
      set(v[i].btn);
      cyc(v[i].hi);
      set(4'b0000);
      cyc(10);
      freeze = 0;
      clear = 0;
      e = sb.pop_front();
      chk($sformatf("vec%0d posJ1", i), posJ1, e.p1);
      chk($sformatf("vec%0d posJ2", i), posJ2, e.p2);
      chk($sformatf("vec%0d moves_j1", i), n1 - b1, e.m1);
      chk($sformatf("vec%0d moves_j2", i), n2 - b2, e.m2);
    end
    b2 = n2;
    freeze = 1;
    set(4'b1000);
    cyc(8);
    freeze = 0;
    cyc(8);
    set(4'b0000);
    cyc(10);
    chk("freeze hold posJ2", posJ2, 1);
    chk("freeze hold moves", n2 - b2, 0);
    b2 = n2;
    set(4'b1000);
    cyc(8);
    set(4'b0000);
    cyc(10);
    chk("after freeze posJ2", posJ2, 2);
    chk("after freeze moves", n2 - b2, 1);
    b1 = n1;
    b2 = n2;
    set(4'b1010);
    cyc(3);
    #1 reset = 0;
    #1;
    chk("async reset posJ2", posJ2, 0);
    chk("async reset move_j2", move_j2, 0);
    set(4'b0000);
    cyc(2);
    reset = 1;
    cyc(12);
    chk("post reset posJ1", posJ1, 0);
    chk("post reset posJ2", posJ2, 0);
    chk("post reset moves", (n1 - b1) + (n2 - b2), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
